// File: rtl/hdmi_scope_renderer.sv
// hdmi_scope_renderer
//   Multi-channel oscilloscope renderer for an HDMI output path, all in the
//   pixel clock domain. Accepts one sample set (one sample per channel) per
//   display column, rasterises each column into the write bank of a
//   ping-pong pair of external BRAM framebuffers (one bit per channel per
//   pixel), generates video timing, and scans the display bank out as
//   coloured 24-bit pixels.
//
//   Optional feature macro: SCOPE_GRID_EN
//     When defined, empty active pixels on every 64th column/row are drawn
//     as a dark grey graticule (24'h404040). Traces cover the grid.
//
// Ports
//   pixclk              pixel clock, all registers on its rising edge
//   rst                 synchronous active-high reset
//   val                 packed samples, channel c at [c*VAL_RES +: VAL_RES]
//   val_valid/val_ready sample-set handshake
//   RD0, RD1            BRAM read data, banks 0/1 (1-cycle synchronous read)
//   VDEn, hSync, vSync  video data enable and sync pulses
//   pixel               24-bit RGB pixel, aligned with VDEn
//   WE0, WE1            bank write enables
//   addrB0, addrB1      bank addresses
//   WD                  write data, shared by both banks
//   frame_swap          one-cycle pulse when display and write banks exchange
module hdmi_scope_renderer #(
  parameter int          ADDR_WIDTH = 19,
  parameter int          VAL_RES    = 12,
  parameter int          CHANNELS   = 2,
  parameter int          H_ACTIVE   = 640,
  parameter int          HFP        = 16,
  parameter int          HS         = 96,
  parameter int          HBP        = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          VFP        = 10,
  parameter int          VS         = 2,
  parameter int          VBP        = 33,
  parameter logic        SYNC_POL   = 1'b0,
  // Channel 0 occupies the low 24 bits.
  parameter logic [95:0] PALETTE    = {24'h00FF00, 24'hFF00FF, 24'h00FFFF, 24'hFFFF00}
) (
  input  logic                         pixclk,
  input  logic                         rst,
  input  logic [CHANNELS*VAL_RES-1:0]  val,
  input  logic                         val_valid,
  output logic                         val_ready,
  input  logic [CHANNELS-1:0]          RD0,
  input  logic [CHANNELS-1:0]          RD1,
  output logic                         VDEn,
  output logic                         hSync,
  output logic                         vSync,
  output logic [23:0]                  pixel,
  output logic                         WE0,
  output logic                         WE1,
  output logic [ADDR_WIDTH-1:0]        addrB0,
  output logic [ADDR_WIDTH-1:0]        addrB1,
  output logic [CHANNELS-1:0]          WD,
  output logic                         frame_swap
);

  localparam int H_TOTAL = H_ACTIVE + HFP + HS + HBP;
  localparam int V_TOTAL = V_ACTIVE + VFP + VS + VBP;
  localparam int XW = $clog2(H_TOTAL + 1);
  localparam int YW = $clog2(V_TOTAL + 1);
  localparam int RW = $clog2(V_ACTIVE + 1);
  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int MW = VAL_RES + RW;

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + HFP);
  localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + HFP + HS);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + VFP);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + VFP + VS);
  localparam logic [ADDR_WIDTH-1:0] A_STEP = ADDR_WIDTH'(H_ACTIVE);
  localparam logic [RW-1:0] R_LAST = RW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(H_ACTIVE - 1);

  typedef enum logic [1:0] {W_IDLE, W_COL, W_DONE} wstate_t;

  logic [XW-1:0]         cx;
  logic [YW-1:0]         cy;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic                  act1, hs1, vs1, sel1;
  logic                  rd_sel;
  logic [CHANNELS-1:0]   bits;

  wstate_t               wstate;
  logic [CW-1:0]         col;
  logic [RW-1:0]         r;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_we;
  logic [CHANNELS-1:0]   wr_data;
  logic [RW-1:0]         row_q    [CHANNELS];
  logic [RW-1:0]         row_next [CHANNELS];
  logic [MW-1:0]         prod;
  logic                  do_swap;

`ifdef SCOPE_GRID_EN
  logic [5:0] gx, gy;
  logic       grid1, grid2;
`endif

  // Raster counters. line_base tracks cy*H_ACTIVE by repeated addition so
  // the scan address never needs a multiplier.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      cx        <= '0;
      cy        <= '0;
      line_base <= '0;
`ifdef SCOPE_GRID_EN
      gx        <= '0;
      gy        <= '0;
`endif
    end else if (cx == X_LAST) begin
      cx <= '0;
`ifdef SCOPE_GRID_EN
      gx <= '0;
`endif
      if (cy == Y_LAST) begin
        cy        <= '0;
        line_base <= '0;
`ifdef SCOPE_GRID_EN
        gy        <= '0;
`endif
      end else begin
        cy        <= cy + YW'(1);
        line_base <= line_base + A_STEP;
`ifdef SCOPE_GRID_EN
        gy        <= gy + 6'd1;
`endif
      end
    end else begin
      cx <= cx + XW'(1);
`ifdef SCOPE_GRID_EN
      gx <= gx + 6'd1;
`endif
    end
  end

  // Two-stage scan pipeline: stage 1 registers the BRAM address, stage 2
  // lines the timing flags up with the BRAM read data. sel1 remembers which
  // bank the stage-1 address was presented to.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      scan_addr <= '0;
      act1      <= 1'b0;
      hs1       <= ~SYNC_POL;
      vs1       <= ~SYNC_POL;
      sel1      <= 1'b0;
      VDEn      <= 1'b0;
      hSync     <= ~SYNC_POL;
      vSync     <= ~SYNC_POL;
`ifdef SCOPE_GRID_EN
      grid1     <= 1'b0;
      grid2     <= 1'b0;
`endif
    end else begin
      scan_addr <= line_base + ADDR_WIDTH'(cx);
      act1      <= (cx < X_ACT) && (cy < Y_ACT);
      hs1       <= (cx >= X_HS0 && cx < X_HS1) ? SYNC_POL : ~SYNC_POL;
      vs1       <= (cy >= Y_VS0 && cy < Y_VS1) ? SYNC_POL : ~SYNC_POL;
      sel1      <= rd_sel;
      VDEn      <= act1;
      hSync     <= hs1;
      vSync     <= vs1;
`ifdef SCOPE_GRID_EN
      grid1     <= (gx == 6'd0) || (gy == 6'd0);
      grid2     <= grid1;
`endif
    end
  end

  // Colour lookup: the loop runs from the highest channel down so the
  // lowest-index set bit is the last assignment and wins.
  always_comb begin
    pixel = 24'h000000;
    bits  = sel1 ? RD1 : RD0;
    if (VDEn) begin
`ifdef SCOPE_GRID_EN
      if (grid2) pixel = 24'h404040;
`endif
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (bits[c]) pixel = PALETTE[24*c +: 24];
      end
    end
  end

  // Sample value to screen row: larger samples sit nearer the top.
  always_comb begin
    prod = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      prod        = MW'(val[c*VAL_RES +: VAL_RES]) * MW'(V_ACTIVE);
      row_next[c] = R_LAST - RW'(prod >> VAL_RES);
    end
  end

  // Banks exchange at the start of vertical blank, but only once the writer
  // has finished a whole frame, including on the very cycle it finishes.
  assign do_swap = (cx == '0) && (cy == Y_ACT) &&
                   ((wstate == W_DONE) ||
                    ((wstate == W_COL) && (r == R_LAST) && (col == C_LAST)));
  assign frame_swap = do_swap & ~rst;

  // Column writer. Write enable/data/address are registered one step ahead
  // so that every W_COL cycle presents exactly one row of the column.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      wstate    <= W_IDLE;
      col       <= '0;
      r         <= '0;
      wr_addr   <= '0;
      wr_we     <= 1'b0;
      wr_data   <= '0;
      val_ready <= 1'b0;
      rd_sel    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) row_q[c] <= '0;
    end else begin
      if (do_swap) rd_sel <= ~rd_sel;
      case (wstate)
        W_IDLE: begin
          val_ready <= 1'b1;
          if (val_valid && val_ready) begin
            for (int c = 0; c < CHANNELS; c++) begin
              row_q[c]   <= row_next[c];
              wr_data[c] <= (row_next[c] == '0);
            end
            r         <= '0;
            wr_addr   <= ADDR_WIDTH'(col);
            wr_we     <= 1'b1;
            val_ready <= 1'b0;
            wstate    <= W_COL;
          end
        end
        W_COL: begin
          if (r == R_LAST) begin
            wr_we   <= 1'b0;
            wr_data <= '0;
            if (col == C_LAST) begin
              col <= '0;
              if (do_swap) begin
                wstate    <= W_IDLE;
                val_ready <= 1'b1;
              end else begin
                wstate <= W_DONE;
              end
            end else begin
              col       <= col + CW'(1);
              wstate    <= W_IDLE;
              val_ready <= 1'b1;
            end
          end else begin
            r       <= r + RW'(1);
            wr_addr <= wr_addr + A_STEP;
            for (int c = 0; c < CHANNELS; c++) begin
              wr_data[c] <= ((r + RW'(1)) == row_q[c]);
            end
          end
        end
        W_DONE: begin
          if (do_swap) begin
            wstate    <= W_IDLE;
            col       <= '0;
            val_ready <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Display bank sees the scan address read-only; write bank sees the writer.
  assign WE0    = rd_sel ? wr_we : 1'b0;
  assign WE1    = rd_sel ? 1'b0 : wr_we;
  assign addrB0 = rd_sel ? wr_addr : scan_addr;
  assign addrB1 = rd_sel ? scan_addr : wr_addr;
  assign WD     = wr_data;

endmodule

// File: tb/tb_hdmi_scope_renderer.sv
// tb_hdmi_scope_renderer
//   Directed bench for hdmi_scope_renderer on an 8x6 active raster
//   (10x8 total). Two behavioural BRAMs with a 1-cycle read sit on the bank
//   ports; a reference raster counter and an expected framebuffer image
//   provide the expected timing and pixel values.
module tb_hdmi_scope_renderer;

  localparam int AW = 6;
  localparam int VR = 12;
  localparam int CH = 2;

  logic                pixclk = 1'b0;
  logic                rst = 1'b1;
  logic [CH*VR-1:0]    val = '0;
  logic                val_valid = 1'b0;
  logic                val_ready;
  logic [CH-1:0]       RD0 = '0;
  logic [CH-1:0]       RD1 = '0;
  logic                VDEn, hSync, vSync;
  logic [23:0]         pixel;
  logic                WE0, WE1;
  logic [AW-1:0]       addrB0, addrB1;
  logic [CH-1:0]       WD;
  logic                frame_swap;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected framebuffer contents per bank, and which bank should be shown.
  logic [1:0] img [0:1][0:47] = '{default: '0};
  int exp_sel = 0;

  // Reference raster position now (mx,my) and as seen at the outputs (mx2,my2).
  int mx = 0, my = 0, mx1 = 0, my1 = 0, mx2 = 0, my2 = 0;
  bit v1 = 1'b0, v2 = 1'b0;

  logic [1:0] mem0 [0:63] = '{default: '0};
  logic [1:0] mem1 [0:63] = '{default: '0};

  hdmi_scope_renderer #(
    .ADDR_WIDTH(AW), .VAL_RES(VR), .CHANNELS(CH),
    .H_ACTIVE(8), .HFP(0), .HS(2), .HBP(0),
    .V_ACTIVE(6), .VFP(0), .VS(2), .VBP(0),
    .SYNC_POL(1'b0)
  ) dut (
    .pixclk(pixclk), .rst(rst), .val(val), .val_valid(val_valid),
    .val_ready(val_ready), .RD0(RD0), .RD1(RD1), .VDEn(VDEn),
    .hSync(hSync), .vSync(vSync), .pixel(pixel), .WE0(WE0), .WE1(WE1),
    .addrB0(addrB0), .addrB1(addrB1), .WD(WD), .frame_swap(frame_swap)
  );

  always #5 pixclk = ~pixclk;

  // Behavioural BRAMs, synchronous read.
  always @(posedge pixclk) begin
    if (WE0) mem0[addrB0] <= WD;
    RD0 <= mem0[addrB0];
    if (WE1) mem1[addrB1] <= WD;
    RD1 <= mem1[addrB1];
  end

  // Reference raster counter with a two-cycle delayed copy.
  always @(posedge pixclk) begin
    if (rst) begin
      mx <= 0; my <= 0; mx1 <= 0; my1 <= 0; mx2 <= 0; my2 <= 0;
      v1 <= 1'b0; v2 <= 1'b0;
    end else begin
      mx <= (mx == 9) ? 0 : mx + 1;
      if (mx == 9) my <= (my == 7) ? 0 : my + 1;
      mx1 <= mx; my1 <= my; v1 <= 1'b1;
      mx2 <= mx1; my2 <= my1; v2 <= v1;
    end
  end

  // Expected colour for a framebuffer cell: channel 0 yellow, channel 1 cyan.
  function automatic logic [23:0] exp_pixel(input logic [1:0] b, input int x, input int y);
    if (b[0]) return 24'hFFFF00;
    if (b[1]) return 24'h00FFFF;
`ifdef SCOPE_GRID_EN
    if ((x % 64 == 0) || (y % 64 == 0)) return 24'h404040;
`endif
    return 24'h000000;
  endfunction

  // Drives a run of columns with a held valid and records the expected
  // column contents; er0/er1 are the hand-computed trace rows.
  task automatic send_columns(input logic [11:0] s0, input logic [11:0] s1,
                              input int first_col, input int ncols,
                              input int er0, input int er1);
    int n;
    int wb;
    wb = 1 - exp_sel;
    val = {s1, s0};
    val_valid = 1'b1;
    for (int k = 0; k < ncols; k++) begin
      n = 0;
      while (val_ready !== 1'b1 && n < 50) begin
        @(negedge pixclk);
        n++;
      end
      if (n >= 50) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL send_handshake col=%0d val_ready=%b required 1", first_col + k, val_ready);
        val_valid = 1'b0;
        return;
      end
      for (int rr = 0; rr < 6; rr++)
        img[wb][first_col + k + 8*rr] = {(rr == er1), (rr == er0)};
      repeat (7) @(negedge pixclk);
    end
    val_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge pixclk);
    @(negedge pixclk);
    tests_run++; if (val_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_val_ready got %b want 0", val_ready); end
    tests_run++; if (VDEn !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_VDEn got %b want 0", VDEn); end
    tests_run++; if (hSync !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_hSync got %b want 1", hSync); end
    tests_run++; if (vSync !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_vSync got %b want 1", vSync); end
    tests_run++; if (pixel !== 24'h0) begin tests_failed++; $display("[TB] FAIL reset_pixel got %h want 000000", pixel); end
    tests_run++; if (WE0 !== 1'b0 || WE1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_WE got %b%b want 00", WE1, WE0); end
    tests_run++; if (addrB0 !== '0 || addrB1 !== '0) begin tests_failed++; $display("[TB] FAIL reset_addr got %0d/%0d want 0/0", addrB0, addrB1); end
    tests_run++; if (WD !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_WD got %b want 00", WD); end
    tests_run++; if (frame_swap !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_swap got %b want 0", frame_swap); end
    rst = 1'b0;
    @(negedge pixclk);
    tests_run++; if (val_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_val_ready got %b want 1", val_ready); end
  endtask

  task automatic test_sync_timing();
    logic ehs, evs, ede;
    for (int i = 0; i < 80; i++) begin
      ede = v2 && mx2 < 8 && my2 < 6;
      ehs = !(v2 && mx2 >= 8);
      evs = !(v2 && my2 >= 6);
      tests_run++; if (VDEn !== ede) begin tests_failed++; $display("[TB] FAIL sync_VDEn x=%0d y=%0d got %b want %b", mx2, my2, VDEn, ede); end
      tests_run++; if (hSync !== ehs) begin tests_failed++; $display("[TB] FAIL sync_hSync x=%0d got %b want %b", mx2, hSync, ehs); end
      tests_run++; if (vSync !== evs) begin tests_failed++; $display("[TB] FAIL sync_vSync y=%0d got %b want %b", my2, vSync, evs); end
      @(negedge pixclk);
    end
  endtask

  // ch0=1000 -> row 4, ch1=4095 -> row 0; bank 1 is the write bank.
  task automatic test_column_write();
    int n;
    logic [1:0] ewd;
    val = {12'd4095, 12'd1000};
    val_valid = 1'b1;
    for (int col = 0; col < 8; col++) begin
      n = 0;
      while (val_ready !== 1'b1 && n < 50) begin
        @(negedge pixclk);
        n++;
      end
      tests_run++;
      if (n >= 50) begin
        tests_failed++;
        $display("[TB] FAIL col_handshake col=%0d val_ready=%b required 1", col, val_ready);
        val_valid = 1'b0;
        return;
      end
      @(negedge pixclk);
      for (int rr = 0; rr < 6; rr++) begin
        ewd = {(rr == 0), (rr == 4)};
        img[1][col + 8*rr] = ewd;
        tests_run++; if (WE1 !== 1'b1 || WE0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL col_we col=%0d r=%0d got WE1=%b WE0=%b want 1/0", col, rr, WE1, WE0); end
        tests_run++; if (addrB1 !== AW'(col + 8*rr)) begin tests_failed++; $display("[TB] FAIL col_addr col=%0d r=%0d got %0d want %0d", col, rr, addrB1, col + 8*rr); end
        tests_run++; if (WD !== ewd) begin tests_failed++; $display("[TB] FAIL col_wd col=%0d r=%0d got %b want %b", col, rr, WD, ewd); end
        tests_run++; if (val_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL col_busy col=%0d r=%0d val_ready=%b want 0", col, rr, val_ready); end
        if (!(col == 7 && rr == 5)) begin
          tests_run++; if (frame_swap !== 1'b0) begin tests_failed++; $display("[TB] FAIL col_no_swap col=%0d r=%0d got %b want 0", col, rr, frame_swap); end
        end
        @(negedge pixclk);
      end
      if (col < 7) begin
        tests_run++; if (val_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL col_throughput col=%0d val_ready=%b want 1", col, val_ready); end
      end
    end
    val_valid = 1'b0;
  endtask

  task automatic test_frame_swap();
    int n;
    logic [23:0] ep;
    n = 0;
    while (frame_swap !== 1'b1 && n < 200) begin
      @(negedge pixclk);
      n++;
    end
    tests_run++;
    if (n >= 200) begin
      tests_failed++;
      $display("[TB] FAIL swap_timeout frame_swap=%b required 1", frame_swap);
      return;
    end
    tests_run++; if (!(mx == 0 && my == 6)) begin tests_failed++; $display("[TB] FAIL swap_position got (%0d,%0d) want (0,6)", mx, my); end
    exp_sel = 1 - exp_sel;
    @(negedge pixclk);
    tests_run++; if (frame_swap !== 1'b0) begin tests_failed++; $display("[TB] FAIL swap_pulse_width got %b want 0", frame_swap); end
    tests_run++; if (val_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL swap_writer_idle val_ready=%b want 1", val_ready); end
    for (int i = 0; i < 80; i++) begin
      @(negedge pixclk);
      ep = 24'h0;
      if (v2 && mx2 < 8 && my2 < 6) ep = exp_pixel(img[exp_sel][my2*8 + mx2], mx2, my2);
      tests_run++; if (pixel !== ep) begin tests_failed++; $display("[TB] FAIL swap_display x=%0d y=%0d got %h want %h", mx2, my2, pixel, ep); end
    end
  endtask

  // ch0=ch1=0 -> both traces on row 5; channel 0 colour must win.
  task automatic test_lowest_wins();
    int n;
    logic [23:0] ep;
    send_columns(12'd0, 12'd0, 0, 8, 5, 5);
    n = 0;
    while (frame_swap !== 1'b1 && n < 200) begin
      @(negedge pixclk);
      n++;
    end
    tests_run++;
    if (n >= 200) begin
      tests_failed++;
      $display("[TB] FAIL lowest_swap_timeout frame_swap=%b required 1", frame_swap);
      return;
    end
    exp_sel = 1 - exp_sel;
    for (int i = 0; i < 80; i++) begin
      @(negedge pixclk);
      ep = 24'h0;
      if (v2 && mx2 < 8 && my2 < 6) ep = (my2 == 5) ? 24'hFFFF00 : exp_pixel(2'b00, mx2, my2);
      tests_run++; if (pixel !== ep) begin tests_failed++; $display("[TB] FAIL lowest_display x=%0d y=%0d got %h want %h", mx2, my2, pixel, ep); end
    end
  endtask

  task automatic test_grid();
    int n;
    logic [23:0] eg;
`ifdef SCOPE_GRID_EN
    eg = 24'h404040;
`else
    eg = 24'h000000;
`endif
    n = 0;
    while (!(v2 && mx2 == 0 && my2 == 2) && n < 100) begin
      @(negedge pixclk);
      n++;
    end
    tests_run++;
    if (n >= 100) begin
      tests_failed++;
      $display("[TB] FAIL grid_timeout position (0,2) not reached");
      return;
    end
    tests_run++; if (pixel !== eg) begin tests_failed++; $display("[TB] FAIL grid_pixel_0_2 got %h want %h", pixel, eg); end
    @(negedge pixclk);
    tests_run++; if (pixel !== 24'h000000) begin tests_failed++; $display("[TB] FAIL grid_pixel_1_2 got %h want 000000", pixel); end
  endtask

  // Three columns then stall (ch0=2048 -> row 2, ch1=4095 -> row 0): no swap,
  // the previous frame keeps being shown.
  task automatic test_stall();
    logic [23:0] ep;
    send_columns(12'd2048, 12'd4095, 0, 3, 2, 0);
    for (int i = 0; i < 100; i++) begin
      tests_run++; if (frame_swap !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_no_swap x=%0d y=%0d got %b want 0", mx, my, frame_swap); end
      @(negedge pixclk);
    end
    for (int i = 0; i < 80; i++) begin
      ep = 24'h0;
      if (v2 && mx2 < 8 && my2 < 6) ep = exp_pixel(img[exp_sel][my2*8 + mx2], mx2, my2);
      tests_run++; if (pixel !== ep) begin tests_failed++; $display("[TB] FAIL stall_display x=%0d y=%0d got %h want %h", mx2, my2, pixel, ep); end
      @(negedge pixclk);
    end
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_column_write();
    test_frame_swap();
    test_lowest_wins();
    test_grid();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
